// File: rtl/one_counter_sequencer_pkg.sv
// Shared constants for the one-counter sequencer: FSM encoding, default word
// width and the fill bit of the timeout sentinel result.
package one_counter_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_LOAD    = 2'b01;
  localparam logic [1:0] ST_WAIT    = 2'b10;
  localparam logic [1:0] ST_CAPTURE = 2'b11;

  // A timed-out job reports a word made entirely of this bit (all-ones).
  localparam logic TIMEOUT_SENTINEL_BIT = 1'b1;

endpackage

// File: rtl/one_counter_sequencer_if.sv
// Word input stream and result output stream of the one-counter sequencer.
// The sequencer is the slave; whoever feeds and drains it is the master.
interface one_counter_sequencer_if
  import one_counter_pkg::*;
  #(parameter int DATA_W = DATA_W_DEF);

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              o_res_valid;
  logic              i_res_ready;
  logic [DATA_W-1:0] o_res_data;
  logic              o_err;

  modport slave (
    input  i_valid, i_data, i_res_ready,
    output o_ready, o_res_valid, o_res_data, o_err
  );

  modport master (
    output i_valid, i_data, i_res_ready,
    input  o_ready, o_res_valid, o_res_data, o_err
  );

endinterface

// File: rtl/one_counter_sequencer_fifo.sv
// Small synchronous FIFO with an extra pointer bit to tell full from empty.
// A push while full is dropped, even if a pop happens in the same cycle.
module sync_fifo_nb
  import one_counter_pkg::*;
  #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF
  ) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              full_next_o
  );

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Lets the owner register a ready flag that is exact on the very next cycle.
  assign full_next_o = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/one_counter_sequencer.sv
// Feeds buffered words one at a time through the external one-counter FSM and
// returns each count (or an all-ones timeout result) on a valid/ready port.
module one_counter_sequencer
  import one_counter_pkg::*;
  #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
  ) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    one_counter_sequencer_if.slave   bus,
    output logic                     o_cnt_rst,
    output logic [DATA_W-1:0]        o_cnt_data,
    input  logic                     i_cnt_done,
    input  logic [DATA_W-1:0]        i_cnt_data
  );

  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] SENTINEL = {DATA_W{TIMEOUT_SENTINEL_BIT}};

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] cnt_data_q, cnt_data_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic              stage_err_q, stage_err_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              ready_q;

  logic              fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty, fifo_full_next;
  logic              res_accept, res_load;

  assign fifo_push  = bus.i_valid & ready_q & ~fifo_full;
  assign res_accept = res_valid_q & bus.i_res_ready;

  sync_fifo_nb #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (i_clk),
    .rst         (i_rst),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .data_i      (bus.i_data),
    .data_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .full_next_o (fifo_full_next)
  );

  // Done takes priority over the timeout when both land in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_data_d  = cnt_data_q;
    timer_d     = timer_q;
    stage_d     = stage_q;
    stage_err_d = stage_err_q;
    fifo_pop    = 1'b0;
    res_load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cnt_data_d = fifo_head;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_cnt_done) begin
          stage_d     = i_cnt_data;
          stage_err_d = 1'b0;
          state_d     = ST_CAPTURE;
        end else if (timer_q == TIMER_LAST) begin
          stage_d     = SENTINEL;
          stage_err_d = 1'b1;
          state_d     = ST_CAPTURE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_CAPTURE: begin
        if (!res_valid_q || res_accept) begin
          res_load = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    res_valid_d = res_load | (res_valid_q & ~res_accept);
    res_data_d  = res_load ? stage_q : res_data_q;
    res_err_d   = res_load ? stage_err_q : res_err_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_data_q  <= '0;
      timer_q     <= '0;
      stage_q     <= '0;
      stage_err_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_data_q  <= cnt_data_d;
      timer_q     <= timer_d;
      stage_q     <= stage_d;
      stage_err_q <= stage_err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      ready_q     <= ~fifo_full_next;
    end
  end

  // The counter is held in reset everywhere except while a job is running.
  assign o_cnt_rst       = (state_q != ST_WAIT);
  assign o_cnt_data      = cnt_data_q;
  assign bus.o_ready     = ready_q;
  assign bus.o_res_valid = res_valid_q;
  assign bus.o_res_data  = res_data_q;
  assign bus.o_err       = res_err_q;

endmodule

// File: tb/tb_one_counter_sequencer.sv
// Directed bench for one_counter_sequencer with a behavioural one-counter
// whose done latency can be set per test (including never finishing).
module tb_one_counter_sequencer;
  import one_counter_pkg::*;

  localparam int DW      = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  one_counter_sequencer_if #(.DATA_W(DW)) seqIf();

  logic          cntRst;
  logic [DW-1:0] cntData;
  logic          cntDone;
  logic [DW-1:0] cntBus;
  int            doneAt = DW + 1;
  int            cyc = 0;

  logic resReadyMain = 1'b1;
  logic toggleVal = 1'b0;
  logic toggleEn = 1'b0;
  assign seqIf.i_res_ready = toggleEn ? toggleVal : resReadyMain;

  one_counter_sequencer #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk      (clock),
    .i_rst      (reset),
    .bus        (seqIf),
    .o_cnt_rst  (cntRst),
    .o_cnt_data (cntData),
    .i_cnt_done (cntDone),
    .i_cnt_data (cntBus)
  );

  // Counter model: done after doneAt cycles out of reset; junk on the bus otherwise.
  always @(posedge clock) begin
    if (cntRst) cyc <= 0;
    else        cyc <= cyc + 1;
  end
  assign cntDone = !cntRst && (cyc >= doneAt);
  assign cntBus  = cntDone ? DW'($countones(cntData)) : 16'hDEAD;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] resQ[$];
  logic          errQ[$];

  always @(negedge clock) begin
    if (!reset && seqIf.o_res_valid && seqIf.i_res_ready) begin
      resQ.push_back(seqIf.o_res_data);
      errQ.push_back(seqIf.o_err);
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      toggleVal = ~toggleVal;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] w);
    int n;
    n = 0;
    seqIf.i_valid = 1'b1;
    seqIf.i_data  = w;
    while (!seqIf.o_ready && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) checkOutput("pushTimeout", 0, 1);
    tick(1);
    seqIf.i_valid = 1'b0;
  endtask

  task automatic tryPush(input logic [DW-1:0] w, output bit accepted);
    accepted      = seqIf.o_ready;
    seqIf.i_valid = 1'b1;
    seqIf.i_data  = w;
    tick(1);
    seqIf.i_valid = 1'b0;
  endtask

  task automatic waitResults(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (resQ.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    checkOutput(tag, resQ.size(), n);
  endtask

  task automatic clearResults();
    resQ.delete();
    errQ.delete();
  endtask

  initial begin
    bit acc;
    int accCount;
    seqIf.i_valid = 1'b0;
    seqIf.i_data  = '0;
    #1;
    tick(2);

    checkOutput("rstReady",    seqIf.o_ready, 0);
    checkOutput("rstCntRst",   cntRst, 1);
    checkOutput("rstCntData",  cntData, 0);
    checkOutput("rstResValid", seqIf.o_res_valid, 0);
    checkOutput("rstResData",  seqIf.o_res_data, 0);
    checkOutput("rstErr",      seqIf.o_err, 0);
    reset = 1'b0;
    tick(1);
    checkOutput("relReady", seqIf.o_ready, 1);

    $display("[TB] basic counts");
    applyStimulus(16'h0000);
    applyStimulus(16'hFFFF);
    applyStimulus(16'h8001);
    waitResults(3, 300, "t1Count");
    checkOutput("t1Res0", resQ[0], 0);
    checkOutput("t1Res1", resQ[1], 16);
    checkOutput("t1Res2", resQ[2], 2);
    checkOutput("t1Err0", errQ[0], 0);
    checkOutput("t1Err1", errQ[1], 0);
    checkOutput("t1Err2", errQ[2], 0);
    clearResults();

    $display("[TB] backpressure and overflow");
    resReadyMain = 1'b0;
    accCount = 0;
    tryPush(16'h0001, acc); accCount += int'(acc);
    tick(40);
    checkOutput("t2HeldValid", seqIf.o_res_valid, 1);
    checkOutput("t2HeldData",  seqIf.o_res_data, 1);
    tryPush(16'h0003, acc); accCount += int'(acc);
    tick(40);
    checkOutput("t2StallCntRst", cntRst, 1);
    tryPush(16'h0007, acc); accCount += int'(acc);
    tryPush(16'h000F, acc); accCount += int'(acc);
    tryPush(16'h001F, acc); accCount += int'(acc);
    tryPush(16'h003F, acc); accCount += int'(acc);
    checkOutput("t2ReadyLow", seqIf.o_ready, 0);
    tryPush(16'h007F, acc); accCount += int'(acc);
    checkOutput("t2Accepted", accCount, 6);
    checkOutput("t2StableData", seqIf.o_res_data, 1);
    resReadyMain = 1'b1;
    waitResults(6, 500, "t2Count");
    tick(60);
    checkOutput("t2NoExtra", resQ.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t2Res%0d", i), resQ[i], i + 1);
    clearResults();

    $display("[TB] timeout");
    resReadyMain = 1'b0;
    doneAt = 1000;
    applyStimulus(16'h00F0);
    tick(33);
    checkOutput("t3NotYet", seqIf.o_res_valid, 0);
    checkOutput("t3WaitCntRst", cntRst, 0);
    tick(2);
    checkOutput("t3Valid", seqIf.o_res_valid, 1);
    checkOutput("t3Data",  seqIf.o_res_data, 16'hFFFF);
    checkOutput("t3Err",   seqIf.o_err, 1);
    doneAt = DW + 1;
    resReadyMain = 1'b1;
    applyStimulus(16'h0003);
    waitResults(2, 300, "t3Count");
    checkOutput("t3Res0", resQ[0], 16'hFFFF);
    checkOutput("t3Err0", errQ[0], 1);
    checkOutput("t3Res1", resQ[1], 2);
    checkOutput("t3Err1", errQ[1], 0);
    clearResults();

    $display("[TB] done coincides with timeout");
    doneAt = TIMEOUT - 1;
    applyStimulus(16'h0F0F);
    waitResults(1, 300, "t4Count");
    checkOutput("t4Res", resQ[0], 8);
    checkOutput("t4Err", errQ[0], 0);
    doneAt = DW + 1;
    clearResults();

    $display("[TB] reset mid-job");
    resReadyMain = 1'b0;
    applyStimulus(16'h0001);
    tick(30);
    applyStimulus(16'h00FF);
    tick(5);
    checkOutput("t5InWait",   cntRst, 0);
    checkOutput("t5PreValid", seqIf.o_res_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("t5CntRst",   cntRst, 1);
    checkOutput("t5ResValid", seqIf.o_res_valid, 0);
    checkOutput("t5Ready",    seqIf.o_ready, 0);
    checkOutput("t5CntData",  cntData, 0);
    tick(2);
    reset = 1'b0;
    resReadyMain = 1'b1;
    tick(1);
    checkOutput("t5RelReady", seqIf.o_ready, 1);
    applyStimulus(16'h0003);
    waitResults(1, 300, "t5Count");
    tick(30);
    checkOutput("t5OnlyOne", resQ.size(), 1);
    checkOutput("t5Res", resQ[0], 2);
    clearResults();

    $display("[TB] toggling result ready");
    toggleEn = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(16'h5555);
    waitResults(6, 800, "t6Count");
    tick(60);
    toggleEn = 1'b0;
    checkOutput("t6NoDup", resQ.size(), 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t6Res%0d", i), resQ[i], 8);
      checkOutput($sformatf("t6Err%0d", i), errQ[i], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
